rv32_mem_arbiter: RTL and testbench
===================================

RV32_MEM_ARBITER -- requirements
Module: rv32_mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 32, meaning the number of 32-bit words in the shared memory (power of 2).
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, meaning the maximum consecutive data grants while an instruction request waits.
REQ-003 SHALL have ports, one per line (name, direction, width, meaning):
  clk  in  1  clock; all state changes on rising edge
  rst  in  1  reset, synchronous, active-high
  i_req  in  1  instruction fetch request
  i_addr  in  32  fetch byte address
  i_gnt  out  1  fetch accepted this cycle
  i_rvalid  out  1  fetch response valid
  i_rdata  out  32  fetch data
  i_err  out  1  fetch error, qualified by i_rvalid
  d_req  in  1  data access request
  d_we  in  1  1 = write, 0 = read
  d_addr  in  32  data byte address
  d_wdata  in  32  write data
  d_gnt  out  1  data access accepted this cycle
  d_rvalid  out  1  data completion, for reads and writes
  d_rdata  out  32  read data; 0 for writes
  d_err  out  1  data error, qualified by d_rvalid
  m_en  out  1  memory access enable
  m_we  out  1  memory write enable
  m_addr  out  $clog2(MEM_WORDS)  memory word index
  m_wdata  out  32  memory write data
  m_rdata  in  32  memory read data, valid one cycle after m_en with m_we=0

Function
REQ-004 SHALL use FSM states IDLE, RESP_I and RESP_D; next state is RESP_I after an i grant, RESP_D after a d grant, otherwise IDLE.
REQ-005 SHALL arbitrate in every state, so back-to-back grants on consecutive cycles are allowed.
REQ-006 SHALL make grants combinational from the current-cycle requests and state.
REQ-007 SHALL assert at most one of i_gnt and d_gnt per cycle.
REQ-008 SHALL require a requester to hold req and its address/data stable until it is granted; a request is consumed on the gnt cycle.
REQ-009 SHALL give d_req priority over i_req, except when the starvation counter equals STARVE_LIMIT, in which case i_req wins.
REQ-010 SHALL increment the starvation counter on each d grant while i_req=1, clear it on an i grant or whenever i_req=0, and saturate it at STARVE_LIMIT.
REQ-011 SHALL, on a valid grant, drive in the same cycle: m_en=1, m_addr=addr[2+:$clog2(MEM_WORDS)], m_we=d_we (d grants only), m_wdata=d_wdata.
REQ-012 SHALL, in RESP_I, assert i_rvalid=1 with i_rdata=m_rdata, exactly one cycle after the grant.
REQ-013 SHALL, in RESP_D, assert d_rvalid=1 with d_rdata=m_rdata for reads and d_rdata=0 for writes.
REQ-014 SHALL treat an address as invalid when addr>=MEM_WORDS*4 or addr[1:0]!=0.
REQ-015 SHALL still grant an invalid request but hold m_en=0 and m_we=0, so no write occurs.
REQ-016 SHALL answer an invalid request on the next cycle with rvalid=1, err=1 and rdata=0; err SHALL be 0 on every valid response.
REQ-017 SHALL keep m_en, m_we, m_addr and m_wdata at 0 when no grant occurs.
REQ-018 SHALL keep each rvalid/rdata/err at 0 outside its own RESP state.

Reset
REQ-019 SHALL, when rst=1 at a clock edge, enter IDLE, clear the starvation counter and clear the registered error flag.
REQ-020 SHALL force i_gnt, d_gnt and all m_* outputs to 0 during any cycle with rst=1, regardless of requests.
REQ-021 SHALL drop any in-flight response when reset is asserted mid-transaction: no rvalid is produced for it after reset.

Verification
REQ-022 Reset: rst=1 for 2 cycles with i_req=d_req=1 -> all gnt, rvalid and m_en stay 0; first grant (d_gnt) occurs in the first cycle after rst=0.
REQ-023 Fetch: mem[1]=0x07b08113, i_req=1, i_addr=0x4 -> i_gnt and m_addr=1 at cycle N; i_rvalid=1 with i_rdata=0x07b08113 at N+1.
REQ-024 Collision: mem[16]=0x3, i_req=1 i_addr=0x0 and d_req=1 d_addr=0x40 read in the same cycle -> d_gnt at N, i_gnt at N+1; d_rdata=0x3 at N+1, i_rvalid at N+2.
REQ-025 Starvation (STARVE_LIMIT=4): d_req held high, i_req held high -> exactly 4 consecutive d grants, then i_gnt; the counter then clears and d wins again.
REQ-026 Errors (MEM_WORDS=32): d_we=1 d_addr=0x80 -> d_gnt, m_en=0, next cycle d_rvalid=1 d_err=1, memory unchanged; i_addr=0x6 -> i_rvalid=1 i_err=1 i_rdata=0.
REQ-027 Write/read: write d_wdata=0x3F to 0x40, then read 0x40 -> write gives d_rvalid with d_rdata=0; read gives d_rdata=0x3F; reset asserted in a RESP_D cycle -> no d_rvalid follows.

Source files
------------

// File: rtl/rv32_mem_arbiter.sv
// rtl/rv32_mem_arbiter.sv - single-port memory arbiter between instruction fetch and data access
module rv32_mem_arbiter #(
    parameter int MEM_WORDS    = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_req,
    input  logic [31:0]                  i_addr,
    output logic                         i_gnt,
    output logic                         i_rvalid,
    output logic [31:0]                  i_rdata,
    output logic                         i_err,
    input  logic                         d_req,
    input  logic                         d_we,
    input  logic [31:0]                  d_addr,
    input  logic [31:0]                  d_wdata,
    output logic                         d_gnt,
    output logic                         d_rvalid,
    output logic [31:0]                  d_rdata,
    output logic                         d_err,
    output logic                         m_en,
    output logic                         m_we,
    output logic [$clog2(MEM_WORDS)-1:0] m_addr,
    output logic [31:0]                  m_wdata,
    input  logic [31:0]                  m_rdata
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, RESP_I, RESP_D} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_starve;
    logic          r_err;
    logic          r_we;

    logic w_i_valid, w_d_valid, w_starved, w_i_win, w_i_gnt, w_d_gnt;

    assign w_i_valid = (i_addr[31:AW+2] == '0) && (i_addr[1:0] == 2'b00);
    assign w_d_valid = (d_addr[31:AW+2] == '0) && (d_addr[1:0] == 2'b00);
    assign w_starved = (r_starve == CW'(STARVE_LIMIT));
    // Data normally wins; a starved fetch takes the slot once the limit is reached.
    assign w_i_win   = i_req && (!d_req || w_starved);
    assign w_i_gnt   = !rst && w_i_win;
    assign w_d_gnt   = !rst && d_req && !w_i_win;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = IDLE;
        if (w_i_gnt) begin
            w_next = RESP_I;
        end else if (w_d_gnt) begin
            w_next = RESP_D;
        end
    end

    // Error and write flags describe the transaction answered in the following RESP cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve <= '0;
            r_err    <= 1'b0;
            r_we     <= 1'b0;
        end else begin
            r_err <= (w_i_gnt && !w_i_valid) || (w_d_gnt && !w_d_valid);
            r_we  <= w_d_gnt && d_we;
            if (w_i_gnt || !i_req) begin
                r_starve <= '0;
            end else if (w_d_gnt && !w_starved) begin
                r_starve <= r_starve + 1'b1;
            end
        end
    end

    always_comb begin
        i_gnt    = w_i_gnt;
        d_gnt    = w_d_gnt;
        m_en     = 1'b0;
        m_we     = 1'b0;
        m_addr   = '0;
        m_wdata  = '0;
        i_rvalid = 1'b0;
        i_rdata  = '0;
        i_err    = 1'b0;
        d_rvalid = 1'b0;
        d_rdata  = '0;
        d_err    = 1'b0;
        if (w_i_gnt && w_i_valid) begin
            m_en   = 1'b1;
            m_addr = i_addr[2 +: AW];
        end else if (w_d_gnt && w_d_valid) begin
            m_en    = 1'b1;
            m_we    = d_we;
            m_addr  = d_addr[2 +: AW];
            m_wdata = d_wdata;
        end
        case (r_state)
            RESP_I: begin
                if (!rst) begin
                    i_rvalid = 1'b1;
                    i_err    = r_err;
                    i_rdata  = r_err ? 32'h0 : m_rdata;
                end
            end
            RESP_D: begin
                if (!rst) begin
                    d_rvalid = 1'b1;
                    d_err    = r_err;
                    d_rdata  = (r_err || r_we) ? 32'h0 : m_rdata;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// tb/tb_rv32_mem_arbiter.sv - directed scoreboard bench for rv32_mem_arbiter
module tb_rv32_mem_arbiter;
    localparam int WORDS = 32;
    localparam int LIMIT = 4;
    localparam int AW    = 5;

    logic          clk, rst;
    logic          i_req, i_gnt, i_rvalid, i_err;
    logic [31:0]   i_addr, i_rdata;
    logic          d_req, d_we, d_gnt, d_rvalid, d_err;
    logic [31:0]   d_addr, d_wdata, d_rdata;
    logic          m_en, m_we;
    logic [AW-1:0] m_addr;
    logic [31:0]   m_wdata, m_rdata;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } resp_t;

    resp_t       q_i[$];
    resp_t       q_d[$];
    logic [31:0] mem    [WORDS];
    logic [31:0] sb_mem [WORDS];
    int          m_cnt   = 0;
    int          n_pass  = 0;
    int          n_total = 0;

    rv32_mem_arbiter #(.MEM_WORDS(WORDS), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
        .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (m_en) begin
            if (m_we) mem[m_addr] <= m_wdata;
            else      m_rdata <= mem[m_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step(input string tag, input logic rs, input logic ir, input logic [31:0] ia,
                        input logic dr, input logic dwe, input logic [31:0] da, input logic [31:0] dw);
        logic        ei, ed, iv, dv, exp_en;
        logic [31:0] exp_addr;
        resp_t       r;
        @(negedge clk);
        rst = rs; i_req = ir; i_addr = ia; d_req = dr; d_we = dwe; d_addr = da; d_wdata = dw;
        #1;
        if (rs) begin
            chk({tag, "/i_rvalid"}, i_rvalid, 0);
            chk({tag, "/d_rvalid"}, d_rvalid, 0);
            q_i.delete();
            q_d.delete();
        end else begin
            chk({tag, "/i_rvalid"}, i_rvalid, q_i.size() != 0);
            if (q_i.size() != 0) begin
                r = q_i.pop_front();
                chk({tag, "/i_rdata"}, i_rdata, r.data);
                chk({tag, "/i_err"}, i_err, r.err);
            end else begin
                chk({tag, "/i_rdata_idle"}, i_rdata, 0);
            end
            chk({tag, "/d_rvalid"}, d_rvalid, q_d.size() != 0);
            if (q_d.size() != 0) begin
                r = q_d.pop_front();
                chk({tag, "/d_rdata"}, d_rdata, r.data);
                chk({tag, "/d_err"}, d_err, r.err);
            end else begin
                chk({tag, "/d_rdata_idle"}, d_rdata, 0);
            end
        end
        iv = (ia < WORDS * 4) && (ia[1:0] == 2'b00);
        dv = (da < WORDS * 4) && (da[1:0] == 2'b00);
        ei = !rs && ir && (!dr || m_cnt == LIMIT);
        ed = !rs && dr && !ei;
        exp_en   = (ei && iv) || (ed && dv);
        exp_addr = (ei && iv) ? 32'(ia[2 +: AW]) : (ed && dv) ? 32'(da[2 +: AW]) : 32'h0;
        chk({tag, "/i_gnt"}, i_gnt, ei);
        chk({tag, "/d_gnt"}, d_gnt, ed);
        chk({tag, "/m_en"}, m_en, exp_en);
        chk({tag, "/m_addr"}, m_addr, exp_addr);
        chk({tag, "/m_we"}, m_we, ed && dv && dwe);
        chk({tag, "/m_wdata"}, m_wdata, (ed && dv) ? dw : 32'h0);
        if (ei) begin
            r.data = iv ? sb_mem[ia[2 +: AW]] : 32'h0;
            r.err  = !iv;
            q_i.push_back(r);
        end
        if (ed) begin
            r.data = (dv && !dwe) ? sb_mem[da[2 +: AW]] : 32'h0;
            r.err  = !dv;
            q_d.push_back(r);
            if (dv && dwe) sb_mem[da[2 +: AW]] = dw;
        end
        if (rs || ei || !ir) m_cnt = 0;
        else if (ed && m_cnt < LIMIT) m_cnt++;
    endtask

    initial begin
        int mism;
        rst = 1'b1; i_req = 1'b1; i_addr = 0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; d_wdata = 0;
        for (int k = 0; k < WORDS; k++) begin
            mem[k]    = 32'hA5A5_0000 ^ (k * 32'h0101_0101);
            sb_mem[k] = 32'hA5A5_0000 ^ (k * 32'h0101_0101);
        end
        mem[1] = 32'h07b0_8113;  sb_mem[1] = 32'h07b0_8113;
        mem[16] = 32'h3;         sb_mem[16] = 32'h3;

        step("rst0", 1, 1, 32'h0, 1, 0, 32'h40, 0);
        step("rst1", 1, 1, 32'h0, 1, 0, 32'h40, 0);
        step("coll_d", 0, 1, 32'h0, 1, 0, 32'h40, 0);
        step("coll_i", 0, 1, 32'h0, 0, 0, 32'h0, 0);
        step("coll_end", 0, 0, 32'h0, 0, 0, 32'h0, 0);
        step("fetch", 0, 1, 32'h4, 0, 0, 32'h0, 0);
        step("fetch_resp", 0, 0, 32'h0, 0, 0, 32'h0, 0);
        for (int k = 0; k < 6; k++) step("starve", 0, 1, 32'h8, 1, 0, 32'h44, 0);
        step("starve_end", 0, 0, 32'h0, 0, 0, 32'h0, 0);
        step("derr_wr", 0, 0, 32'h0, 1, 1, 32'h80, 32'hDEAD_BEEF);
        step("ierr_mis", 0, 1, 32'h6, 0, 0, 32'h0, 0);
        step("ierr_resp", 0, 0, 32'h0, 0, 0, 32'h0, 0);
        step("derr_mis", 0, 0, 32'h0, 1, 0, 32'h42, 0);
        step("derr_high", 0, 0, 32'h0, 1, 0, 32'hFFFF_FFFC, 0);
        step("last_word", 0, 1, 32'h7C, 0, 0, 32'h0, 0);
        step("wr", 0, 0, 32'h0, 1, 1, 32'h40, 32'h3F);
        step("rd", 0, 0, 32'h0, 1, 0, 32'h40, 0);
        step("rd_resp", 0, 0, 32'h0, 0, 0, 32'h0, 0);
        step("rd2", 0, 0, 32'h0, 1, 0, 32'h40, 0);
        step("rst_mid", 1, 0, 32'h0, 0, 0, 32'h0, 0);
        step("post_rst", 0, 0, 32'h0, 0, 0, 32'h0, 0);
        step("post_rst2", 0, 0, 32'h0, 0, 0, 32'h0, 0);
        mism = 0;
        for (int k = 0; k < WORDS; k++) if (mem[k] !== sb_mem[k]) mism++;
        chk("mem_image", mism, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
